// File: rtl/instruction_encoder_pkg.sv
// Shared instruction word layout and encoder state encoding.
// The instruction decoder uses the same field constants, so the two blocks share one bit layout.
package instruction_encoder_pkg;

   localparam int INSTR_W = 16;

   localparam int OP_MSB  = 15;
   localparam int OP_LSB  = 13;
   localparam int RD_MSB  = 12;
   localparam int RD_LSB  = 9;
   localparam int RS1_MSB = 8;
   localparam int RS1_LSB = 5;
   localparam int RS2_MSB = 4;
   localparam int RS2_LSB = 1;
   localparam int WE_BIT  = 0;

   localparam int OP_W  = OP_MSB - OP_LSB + 1;
   localparam int RD_W  = RD_MSB - RD_LSB + 1;
   localparam int RS1_W = RS1_MSB - RS1_LSB + 1;
   localparam int RS2_W = RS2_MSB - RS2_LSB + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_DONE = 2'd2
   } enc_state_t;

endpackage

// File: rtl/instruction_encoder_instr_field_pack.sv
// instr_field_pack: combinational packer from instruction fields to one instruction word.
// Ports: i_op, i_rd, i_rs1, i_rs2, i_we are the fields; o_word is the packed word.
module instr_field_pack
   import instruction_encoder_pkg::*;
(
   input  logic [OP_W-1:0]    i_op,
   input  logic [RD_W-1:0]    i_rd,
   input  logic [RS1_W-1:0]   i_rs1,
   input  logic [RS2_W-1:0]   i_rs2,
   input  logic               i_we,
   output logic [INSTR_W-1:0] o_word
);

   always_comb begin
      o_word                   = '0;
      o_word[OP_MSB:OP_LSB]    = i_op;
      o_word[RD_MSB:RD_LSB]    = i_rd;
      o_word[RS1_MSB:RS1_LSB]  = i_rs1;
      o_word[RS2_MSB:RS2_LSB]  = i_rs2;
      o_word[WE_BIT]           = i_we;
   end

endmodule

// File: rtl/instruction_encoder.sv
// instruction_encoder: packs field tuples into words and streams them to instruction memory.
// Ports: start/base_addr/length open a session, in_* is the tuple stream, mem_* is the write port, busy/done/words_written report status.
module instruction_encoder
   import instruction_encoder_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [ADDR_W-1:0]  base_addr,
   input  logic [ADDR_W:0]    length,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [OP_W-1:0]    in_op,
   input  logic [RD_W-1:0]    in_rd,
   input  logic [RS1_W-1:0]   in_rs1,
   input  logic [RS2_W-1:0]   in_rs2,
   input  logic               in_we,
   output logic               mem_we,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [INSTR_W-1:0] mem_wdata,
   output logic               busy,
   output logic               done,
   output logic [ADDR_W:0]    words_written
);

   enc_state_t          r_state;
   enc_state_t          w_next;
   logic [ADDR_W-1:0]   r_addr;
   logic [ADDR_W:0]     r_remaining;
   logic [ADDR_W:0]     r_words;
   logic                r_mem_we;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [INSTR_W-1:0]  r_mem_wdata;
   logic [INSTR_W-1:0]  w_word;
   logic                w_hs;
   logic                w_accept;

   instr_field_pack u_pack (
      .i_op   (in_op),
      .i_rd   (in_rd),
      .i_rs1  (in_rs1),
      .i_rs2  (in_rs2),
      .i_we   (in_we),
      .o_word (w_word)
   );

   assign w_hs     = in_valid && (r_state == S_LOAD);
   assign w_accept = start && (r_state == S_IDLE);

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (start) begin
               w_next = (length == '0) ? S_DONE : S_LOAD;
            end
         end
         S_LOAD: begin
            // The handshake that consumes the last remaining word ends the session.
            if (w_hs && (r_remaining == (ADDR_W+1)'(1))) begin
               w_next = S_DONE;
            end
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_addr      <= '0;
         r_remaining <= '0;
         r_words     <= '0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         r_state  <= w_next;
         r_mem_we <= w_hs;
         if (w_accept) begin
            r_addr      <= base_addr;
            r_remaining <= length;
            r_words     <= '0;
         end
         // Count on the handshake edge so the count already includes the
         // word being presented while mem_we is high.
         if (w_hs) begin
            r_mem_addr  <= r_addr;
            r_mem_wdata <= w_word;
            r_addr      <= r_addr + ADDR_W'(1);
            r_remaining <= r_remaining - (ADDR_W+1)'(1);
            r_words     <= r_words + (ADDR_W+1)'(1);
         end
      end
   end

   assign in_ready      = (r_state == S_LOAD);
   assign busy          = (r_state != S_IDLE);
   assign done          = (r_state == S_DONE);
   assign mem_we        = r_mem_we;
   assign mem_addr      = r_mem_addr;
   assign mem_wdata     = r_mem_wdata;
   assign words_written = r_words;

endmodule

// File: doc/instruction_encoder.md
# instruction_encoder

Packs decoded instruction fields into 16-bit instruction words and streams them into instruction memory at consecutive addresses. It is the inverse of the instruction decoder and shares the same bit layout: op[15:13], rd[12:9], rs1[8:5], rs2[4:1], we[0]. It sits between the program loader or test host and the instruction memory write port. It runs one load session per `start` pulse.

## Interface
Parameters:
- `ADDR_W`, 8, instruction memory address width; addresses wrap modulo 2^ADDR_W.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  begins a session. Sampled only in IDLE.
- `base_addr`  in  ADDR_W  first write address. Sampled with `start`.
- `length`  in  ADDR_W+1  number of words to write, 0..2^ADDR_W. Sampled with `start`.
- `in_valid`  in  1  field tuple valid.
- `in_ready`  out  1  encoder accepts a tuple this cycle.
- `in_op`  in  3  opcode field.
- `in_rd`  in  4  write register field.
- `in_rs1`  in  4  read register 1 field.
- `in_rs2`  in  4  read register 2 field.
- `in_we`  in  1  write-enable bit.
- `mem_we`  out  1  instruction memory write strobe, registered.
- `mem_addr`  out  ADDR_W  write address, registered.
- `mem_wdata`  out  16  encoded word, registered.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse at session end.
- `words_written`  out  ADDR_W+1  words written in the current or last session.

## Operation
- States: IDLE, LOAD, DONE.
  - IDLE → LOAD on `start` when `length`≠0.
  - IDLE → DONE on `start` when `length`=0.
  - LOAD → DONE on the handshake that takes `remaining` to 0.
  - DONE → IDLE unconditionally.
- `start` in LOAD or DONE is ignored. Base, length and counters are not disturbed.
- `in_ready` = (state == LOAD). A handshake is `in_valid && in_ready`.
- Each handshake produces word = {in_op, in_rd, in_rs1, in_rs2, in_we}. No field checking; all 16-bit patterns are legal.
- The write address starts at `base_addr` and increments by 1 per handshake, wrapping at 2^ADDR_W.
- `remaining` loads `length` on start and decrements per handshake.
- `words_written` clears to 0 on an accepted `start`, increments on each `mem_we`, and holds after `done` until the next accepted `start`.
- The memory port has no backpressure; the memory accepts every `mem_we`.
- Reset values: `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `done`=0, `words_written`=0; state is IDLE.
- Reset mid-session aborts immediately. Words already written stay in memory; no further writes occur.

## Timing
- `start` sampled at cycle t: `busy` and `in_ready` are high from t+1.
- Handshake at cycle k: `mem_we`=1 at k+1, with `mem_addr`/`mem_wdata` for that tuple. Latency is 1 cycle.
- Throughput is one word per cycle with back-to-back valid.
- Handshake at k is the last one:
  - state is DONE at k+1, `in_ready`=0, and `done`=1 in the same cycle as the final `mem_we`;
  - state is IDLE at k+2, and a new `start` is accepted at k+2.
- `length`=0 with `start` at t: `done`=1 at t+1, no `mem_we`, IDLE at t+2.
- `mem_addr`/`mem_wdata` hold their last values when `mem_we`=0.

## Structure
- Shared package holds:
  - `INSTR_W`=16;
  - field MSB/LSB constants for op, rd, rs1, rs2, we;
  - field widths;
  - the state enum.
- The decoder is migrated to the same field constants so the two blocks cannot diverge.
- Natural sub-module: `instr_field_pack`, a purely combinational field-to-word packer built from the package constants. The FSM, counters and output registers stay in `instruction_encoder`.

## Test plan
- Basic session: base=0x10, length=3, tuples (op=5, rd=2, rs1=3, rs2=4, we=1) then two others, back-to-back.
  - Required: writes at 0x10, 0x11, 0x12 on consecutive cycles; first word 0xA469; `done` with the third `mem_we`; `words_written`=3.
- Wrap: base=0xFF, length=2.
  - Required: `mem_addr` 0xFF then 0x00.
- Bubbles: length=4 with `in_valid` toggling 1,0,0,1,1,0,1.
  - Required: exactly 4 writes at contiguous addresses, each one cycle after its handshake; no write on bubble cycles.
- Zero length plus ignored start: `length`=0.
  - Required: `done` at t+1, no `mem_we`.
  - Then a `start` with new base/length during LOAD of a 3-word session: no effect on addresses or count.
- Reset mid-session: `rst` after 2 of 5 words.
  - Required: all outputs at reset values next cycle, no further `mem_we`.
  - A new session afterward runs correctly from its own base.
